// File: rtl/branch_predict_unit.sv
// Branch predictor: direct-mapped BTB with saturating direction counters, EX-stage resolution, and saturating statistics counters.
// Latency: lookup and resolution are combinational; BTB and statistics updates take effect on the next rising edge.
// Backpressure: none; ex_valid qualifies every update and the unit never stalls.
module branch_predict_unit #(
    parameter int PC_W      = 9,
    parameter int BTB_DEPTH = 16,
    parameter int CNT_W     = 2,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    output logic              pred_taken,
    output logic [PC_W-1:0]   pred_target,
    input  logic              ex_valid,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [31:0]       ex_imm,
    input  logic              ex_branch,
    input  logic              ex_jump,
    input  logic              ex_jalr,
    input  logic [31:0]       ex_alu_result,
    input  logic              ex_pred_taken,
    input  logic [PC_W-1:0]   ex_pred_target,
    output logic [31:0]       ex_pc_four,
    output logic              mispredict,
    output logic [PC_W-1:0]   redirect_pc,
    output logic [STAT_W-1:0] br_count,
    output logic [STAT_W-1:0] mis_count
);

    localparam int IDX_W = $clog2(BTB_DEPTH);
    localparam int TAG_W = PC_W - IDX_W - 2;

    localparam logic [PC_W-1:0]   PC_FOUR   = PC_W'(4);
    localparam logic [CNT_W-1:0]  CTR_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]  CTR_WEAK  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [STAT_W-1:0] STAT_MAX  = {STAT_W{1'b1}};

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [TAG_W-1:0] tag_t;

    // One BTB line; the whole line is written in a single assignment so it is never half-updated.
    typedef struct packed {
        logic             vld;
        tag_t             tag;
        logic [PC_W-1:0]  target;
        logic [CNT_W-1:0] ctr;
    } btb_entry_t;

    btb_entry_t btb [BTB_DEPTH];

    // Fetch-side lookup signals
    idx_t       if_idx;
    tag_t       if_tag;
    btb_entry_t if_ent;
    logic       if_hit;

    // EX-side lookup and resolution signals
    idx_t       ex_idx;
    tag_t       ex_tag;
    btb_entry_t ex_ent;
    logic       ex_hit;
    logic       ex_cf;
    logic       ex_taken;
    logic [PC_W-1:0] ex_target;
    logic [PC_W-1:0] ex_seq_pc;
    logic       target_wrong;

    // BTB write request for this cycle
    logic       upd_en;
    btb_entry_t upd_ent;

    // Immediate and ALU bits above the PC width are architecturally irrelevant here.
    logic unused_hi_bits;
    assign unused_hi_bits = ^{ex_imm[31:PC_W], ex_alu_result[31:PC_W]};

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[PC_W-1:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[PC_W-1:IDX_W+2];

    // Fetch prediction straight from stored state; a same-cycle update is deliberately not bypassed.
    always_comb begin
        if_ent      = btb[if_idx];
        if_hit      = if_ent.vld && (if_ent.tag == if_tag);
        pred_taken  = if_hit && if_ent.ctr[CNT_W-1];
        pred_target = pred_taken ? if_ent.target : (if_pc + PC_FOUR);
    end

    // Resolve the EX instruction: actual direction, target and the correct next PC.
    always_comb begin
        ex_ent      = btb[ex_idx];
        ex_hit      = ex_ent.vld && (ex_ent.tag == ex_tag);
        ex_cf       = ex_branch | ex_jump | ex_jalr;
        ex_taken    = ex_jump | ex_jalr | (ex_branch & ex_alu_result[0]);
        ex_seq_pc   = ex_pc + PC_FOUR;
        ex_target   = ex_jalr ? {ex_alu_result[PC_W-1:1], 1'b0}
                              : (ex_pc + ex_imm[PC_W-1:0]);
        redirect_pc = ex_taken ? ex_target : ex_seq_pc;
        ex_pc_four  = 32'(ex_pc) + 32'd4;
    end

    // Compare the carried prediction against the real outcome; non-branches must not have been predicted taken.
    always_comb begin
        target_wrong = ex_taken && (ex_pred_target != ex_target);
        mispredict   = 1'b0;
        if (ex_valid) begin
            if (ex_cf) begin
                mispredict = (ex_taken != ex_pred_taken) || target_wrong;
            end else begin
                mispredict = ex_pred_taken;
            end
        end
    end

    // Build the next BTB line for the EX index: train on hits, allocate on taken misses, drop aliases.
    always_comb begin
        upd_en  = 1'b0;
        upd_ent = ex_ent;
        if (ex_valid) begin
            if (ex_cf) begin
                if (ex_hit) begin
                    upd_en = 1'b1;
                    if (ex_taken) begin
                        upd_ent.target = ex_target;
                        if (ex_ent.ctr != CTR_MAX) begin
                            upd_ent.ctr = ex_ent.ctr + CNT_W'(1);
                        end
                    end else if (ex_ent.ctr != '0) begin
                        upd_ent.ctr = ex_ent.ctr - CNT_W'(1);
                    end
                end else if (ex_taken) begin
                    upd_en         = 1'b1;
                    upd_ent.vld    = 1'b1;
                    upd_ent.tag    = ex_tag;
                    upd_ent.target = ex_target;
                    upd_ent.ctr    = CTR_WEAK;
                end
            end else if (ex_hit) begin
                // A non-control-flow instruction matched: the entry is a stale alias.
                upd_en      = 1'b1;
                upd_ent.vld = 1'b0;
            end
        end
    end

    // BTB storage; reset wins over any write in flight so no partial line survives.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BTB_DEPTH; i++) begin
                btb[i] <= '0;
            end
        end else if (upd_en) begin
            btb[ex_idx] <= upd_ent;
        end
    end

    // Saturating event counters for resolved control flow and mispredicts.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            br_count  <= '0;
            mis_count <= '0;
        end else begin
            if (ex_valid && ex_cf && (br_count != STAT_MAX)) begin
                br_count <= br_count + STAT_W'(1);
            end
            if (mispredict && (mis_count != STAT_MAX)) begin
                mis_count <= mis_count + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

    localparam int PC_W   = 9;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 2;
    localparam int STAT_W = 16;

    localparam int unsigned PC_MOD   = 1 << PC_W;
    localparam int unsigned CTR_TOP  = (1 << CNT_W) - 1;
    localparam int unsigned CTR_INIT = 1 << (CNT_W - 1);
    localparam int unsigned STAT_TOP = (1 << STAT_W) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [PC_W-1:0]   if_pc;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;
    logic              ex_valid;
    logic [PC_W-1:0]   ex_pc;
    logic [31:0]       ex_imm;
    logic              ex_branch;
    logic              ex_jump;
    logic              ex_jalr;
    logic [31:0]       ex_alu_result;
    logic              ex_pred_taken;
    logic [PC_W-1:0]   ex_pred_target;
    logic [31:0]       ex_pc_four;
    logic              mispredict;
    logic [PC_W-1:0]   redirect_pc;
    logic [STAT_W-1:0] br_count;
    logic [STAT_W-1:0] mis_count;

    always #5 clk = ~clk;

    branch_predict_unit #(
        .PC_W(PC_W), .BTB_DEPTH(DEPTH), .CNT_W(CNT_W), .STAT_W(STAT_W)
    ) dut (
        .clk(clk), .reset(reset), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_imm(ex_imm),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_jalr(ex_jalr),
        .ex_alu_result(ex_alu_result), .ex_pred_taken(ex_pred_taken),
        .ex_pred_target(ex_pred_target), .ex_pc_four(ex_pc_four),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .br_count(br_count), .mis_count(mis_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: table of lines indexed by word address, plus plain integer statistics.
    bit          m_valid [DEPTH];
    int unsigned m_tag   [DEPTH];
    int unsigned m_tgt   [DEPTH];
    int unsigned m_ctr   [DEPTH];
    int unsigned m_br;
    int unsigned m_mis;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned idx_of(input int unsigned pc);
        return (pc / 4) % DEPTH;
    endfunction

    function automatic int unsigned tag_of(input int unsigned pc);
        return pc / (4 * DEPTH);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) begin
            m_valid[i] = 1'b0;
            m_tag[i]   = 0;
            m_tgt[i]   = 0;
            m_ctr[i]   = 0;
        end
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic model_predict(input int unsigned pc, output bit tk, output int unsigned tgt);
        int unsigned i;
        i   = idx_of(pc);
        tk  = m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_ctr[i] >= CTR_INIT);
        tgt = tk ? m_tgt[i] : (pc + 4) % PC_MOD;
    endtask

    // Outcome of the instruction currently presented at EX, from the architectural rules.
    task automatic model_resolve(output bit cf, output bit tk, output int unsigned tgt,
                                 output int unsigned redir, output bit mis);
        int unsigned pc;
        pc  = int'(ex_pc);
        cf  = ex_branch || ex_jump || ex_jalr;
        tk  = ex_jump || ex_jalr || (ex_branch && ex_alu_result[0]);
        if (ex_jalr) tgt = (ex_alu_result % PC_MOD) & ~32'd1;
        else         tgt = (pc + ex_imm) % PC_MOD;
        redir = tk ? tgt : (pc + 4) % PC_MOD;
        if (!ex_valid)  mis = 1'b0;
        else if (cf)    mis = (tk != ex_pred_taken) || (tk && (int'(ex_pred_target) != tgt));
        else            mis = ex_pred_taken;
    endtask

    task automatic model_update();
        bit cf, tk, mis, hit;
        int unsigned tgt, redir, i, t;
        model_resolve(cf, tk, tgt, redir, mis);
        if (!ex_valid) return;
        i   = idx_of(int'(ex_pc));
        t   = tag_of(int'(ex_pc));
        hit = m_valid[i] && (m_tag[i] == t);
        if (cf) begin
            if (hit && tk) begin
                m_tgt[i] = tgt;
                if (m_ctr[i] < CTR_TOP) m_ctr[i]++;
            end else if (hit) begin
                if (m_ctr[i] > 0) m_ctr[i]--;
            end else if (tk) begin
                m_valid[i] = 1'b1;
                m_tag[i]   = t;
                m_tgt[i]   = tgt;
                m_ctr[i]   = CTR_INIT;
            end
            if (m_br < STAT_TOP) m_br++;
        end else if (hit) begin
            m_valid[i] = 1'b0;
        end
        if (mis && m_mis < STAT_TOP) m_mis++;
    endtask

    task automatic drive(input bit v, input bit br, input bit jp, input bit jr,
                         input int unsigned pc, input int unsigned imm, input int unsigned alu,
                         input bit ptk, input int unsigned ptgt, input int unsigned ipc);
        ex_valid       = v;
        ex_branch      = br;
        ex_jump        = jp;
        ex_jalr        = jr;
        ex_pc          = PC_W'(pc);
        ex_imm         = imm;
        ex_alu_result  = alu;
        ex_pred_taken  = ptk;
        ex_pred_target = PC_W'(ptgt);
        if_pc          = PC_W'(ipc);
        #1;
    endtask

    // Compare every output against the model, then clock the DUT and the model together.
    task automatic finish_cycle(input string tag);
        bit cf, tk, mis, ptk;
        int unsigned tgt, redir, ptgt;
        model_resolve(cf, tk, tgt, redir, mis);
        model_predict(int'(if_pc), ptk, ptgt);
        check({tag, ".pred_taken"},  32'(pred_taken),  32'(ptk));
        check({tag, ".pred_target"}, 32'(pred_target), ptgt);
        check({tag, ".mispredict"},  32'(mispredict),  32'(mis));
        check({tag, ".redirect_pc"}, 32'(redirect_pc), redir);
        check({tag, ".ex_pc_four"},  ex_pc_four,       int'(ex_pc) + 4);
        check({tag, ".br_count"},    32'(br_count),    m_br);
        check({tag, ".mis_count"},   32'(mis_count),   m_mis);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    initial begin
        int unsigned pcs [6];
        bit ptk;
        int unsigned ptgt, pc, kind;

        pcs = '{32'h040, 32'h0C0, 32'h044, 32'h1FC, 32'h100, 32'h080};
        reset = 1'b0;
        model_clear();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h040);
        repeat (2) @(negedge clk);
        check("rst.pred_taken",  32'(pred_taken),  0);
        check("rst.pred_target", 32'(pred_target), 32'h044);
        check("rst.br_count",    32'(br_count),    0);
        check("rst.mis_count",   32'(mis_count),   0);
        reset = 1'b1;
        @(negedge clk);

        // Taken BEQ with no prediction: redirect and allocate.
        drive(1, 1, 0, 0, 32'h040, 32'h20, 1, 0, 0, 32'h040);
        check("beq.mispredict",  32'(mispredict),  1);
        check("beq.redirect",    32'(redirect_pc), 32'h060);
        check("beq.pc_four",     ex_pc_four,       32'h044);
        finish_cycle("beq");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h040);
        check("alloc.pred_taken",  32'(pred_taken),  1);
        check("alloc.pred_target", 32'(pred_target), 32'h060);
        finish_cycle("alloc");

        // Train up twice, then down twice: hysteresis of the 2-bit counter.
        repeat (2) begin
            drive(1, 1, 0, 0, 32'h040, 32'h20, 1, 1, 32'h060, 32'h040);
            check("train.mispredict", 32'(mispredict), 0);
            finish_cycle("train_up");
        end
        drive(1, 1, 0, 0, 32'h040, 32'h20, 0, 1, 32'h060, 32'h040);
        check("nt1.redirect", 32'(redirect_pc), 32'h044);
        finish_cycle("nt1");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h040);
        check("nt1.still_taken", 32'(pred_taken), 1);
        finish_cycle("nt1_look");
        drive(1, 1, 0, 0, 32'h040, 32'h20, 0, 1, 32'h060, 32'h040);
        finish_cycle("nt2");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h040);
        check("nt2.not_taken", 32'(pred_taken), 0);
        check("nt2.mis_count", 32'(mis_count),  3);
        finish_cycle("nt2_look");

        // JALR retargets the line; a different tag at the same index misses.
        drive(1, 0, 0, 1, 32'h040, 0, 32'h0000_0127, 0, 0, 32'h0C0);
        check("jalr.redirect",   32'(redirect_pc), 32'h126);
        check("jalr.mispredict", 32'(mispredict),  1);
        finish_cycle("jalr");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0C0);
        check("alias.pred_taken",  32'(pred_taken),  0);
        check("alias.pred_target", 32'(pred_target), 32'h0C4);
        finish_cycle("alias");

        // Non-control-flow predicted taken: flush, invalidate, but same-cycle lookup sees the old line.
        drive(1, 0, 0, 0, 32'h040, 0, 0, 1, 32'h126, 32'h040);
        check("ncf.mispredict",  32'(mispredict),  1);
        check("ncf.redirect",    32'(redirect_pc), 32'h044);
        check("ncf.old_hit",     32'(pred_taken),  1);
        check("ncf.old_target",  32'(pred_target), 32'h126);
        finish_cycle("ncf");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h040);
        check("ncf.invalidated", 32'(pred_taken), 0);
        finish_cycle("ncf_look");

        // Randomised traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            pc   = ($urandom_range(0, 3) == 0) ? ($urandom % PC_MOD) & ~32'd3 : pcs[$urandom_range(0, 5)];
            kind = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                model_predict(pc, ptk, ptgt);
            end else begin
                ptk  = 1'($urandom);
                ptgt = $urandom % PC_MOD;
            end
            drive(1'($urandom_range(0, 4) != 0), kind == 0, kind == 1, kind == 2,
                  pc, $urandom, $urandom, ptk, ptgt, pcs[$urandom_range(0, 5)]);
            finish_cycle("rand");
        end

        // Push the resolved-branch counter past its ceiling.
        drive(1, 1, 0, 0, 32'h1F0, 32'h10, 0, 0, 0, 32'h040);
        for (int n = 0; n < 65540; n++) begin
            @(posedge clk);
            model_update();
        end
        @(negedge clk);
        check("sat.br_count", 32'(br_count), 32'hFFFF);
        finish_cycle("sat_hold");
        check("sat.no_wrap", 32'(br_count), 32'hFFFF);

        // Allocate a line, then assert reset mid-cycle while an update is presented.
        drive(1, 0, 1, 0, 32'h080, 32'h40, 0, 0, 0, 32'h080);
        finish_cycle("jal");
        drive(1, 1, 0, 0, 32'h080, 32'h40, 1, 0, 0, 32'h080);
        check("pre_rst.pred_taken", 32'(pred_taken), 1);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check("arst.pred_taken",  32'(pred_taken),  0);
        check("arst.pred_target", 32'(pred_target), 32'h084);
        check("arst.br_count",    32'(br_count),    0);
        check("arst.mis_count",   32'(mis_count),   0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h080);
        check("post_rst.pred_taken", 32'(pred_taken), 0);
        finish_cycle("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
